// File: rtl/le_cmp_pkg.sv
// Shared types and sizing helpers for the serial less-or-equal comparator.
package le_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  function automatic int digit_count(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/le_serial_cmp_if.sv
// Start/done request bus between a requester and the serial comparator.
interface le_serial_cmp_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode_lt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             le;
  logic             eq;

  modport master (output start, mode_lt, a, b, input busy, done, le, eq);
  modport slave  (input start, mode_lt, a, b, output busy, done, le, eq);
endinterface

// File: rtl/le_digit_cmp.sv
// Combinational compare of one DIGIT-bit slice; invert_msb turns the slice
// into an offset-binary view so two's-complement sign digits order correctly.
module le_digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  input  logic             invert_msb,
  output logic             lt,
  output logic             gt
);
  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  logic [DIGIT-1:0] da_m;
  logic [DIGIT-1:0] db_m;

  assign da_m = invert_msb ? (da ^ MSB_MASK) : da;
  assign db_m = invert_msb ? (db ^ MSB_MASK) : db;
  assign lt   = da_m < db_m;
  assign gt   = da_m > db_m;
endmodule

// File: rtl/le_serial_cmp.sv
// Multi-cycle a<=b / a<b comparator: scans operands MSB-first, DIGIT bits per
// cycle, with optional exit on the first differing digit.
module le_serial_cmp
  import le_cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter bit SIGNED     = 1'b0,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  le_serial_cmp_if.slave bus
);
  localparam int            N    = digit_count(WIDTH, DIGIT);
  localparam int            CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             decided_q;
  logic             lt_q;
  logic             busy_q;
  logic             done_q;
  logic             le_q;
  logic             eq_q;

  logic             dig_lt;
  logic             dig_gt;
  logic             inv_msb;
  logic             decided_d;
  logic             lt_d;
  logic             finish;

  assign inv_msb = SIGNED && (cnt_q == '0);

  le_digit_cmp #(
    .DIGIT(DIGIT)
  ) u_digit (
    .da        (a_q[WIDTH-1 -: DIGIT]),
    .db        (b_q[WIDTH-1 -: DIGIT]),
    .invert_msb(inv_msb),
    .lt        (dig_lt),
    .gt        (dig_gt)
  );

  // Once a difference is seen it is sticky; later digits cannot override it.
  assign decided_d = decided_q | dig_lt | dig_gt;
  assign lt_d      = decided_q ? lt_q : dig_lt;
  assign finish    = (decided_d && EARLY_EXIT) || (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      decided_q <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      le_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            mode_q    <= bus.mode_lt;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          a_q       <= a_q << DIGIT;
          b_q       <= b_q << DIGIT;
          cnt_q     <= cnt_q + 1'b1;
          decided_q <= decided_d;
          lt_q      <= lt_d;
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            eq_q    <= ~decided_d;
            le_q    <= decided_d ? lt_d : ~mode_q;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.le   = le_q;
  assign bus.eq   = eq_q;
endmodule

// File: tb/tb_le_serial_cmp.sv
// Directed checks of le_serial_cmp across several parameter sets sharing one clock.
module tb_le_serial_cmp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        start_v [5];
  logic        mode_v  [5];
  logic [15:0] a_v     [5];
  logic [15:0] b_v     [5];
  logic        busy_v  [5];
  logic        done_v  [5];
  logic        le_v    [5];
  logic        eq_v    [5];

  // 0: W4 D1 unsigned early | 1: W8 D2 unsigned early | 2: W8 D2 full scan
  // 3: W4 D1 signed early   | 4: W16 D1 unsigned early
  le_serial_cmp_if #(.WIDTH(4))  if0 ();
  le_serial_cmp_if #(.WIDTH(8))  if1 ();
  le_serial_cmp_if #(.WIDTH(8))  if2 ();
  le_serial_cmp_if #(.WIDTH(4))  if3 ();
  le_serial_cmp_if #(.WIDTH(16)) if4 ();

  le_serial_cmp #(.WIDTH(4),  .DIGIT(1), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  le_serial_cmp #(.WIDTH(8),  .DIGIT(2), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  le_serial_cmp #(.WIDTH(8),  .DIGIT(2), .SIGNED(1'b0), .EARLY_EXIT(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2));
  le_serial_cmp #(.WIDTH(4),  .DIGIT(1), .SIGNED(1'b1), .EARLY_EXIT(1'b1)) u3 (.clk(clk), .rst(rst), .bus(if3));
  le_serial_cmp #(.WIDTH(16), .DIGIT(1), .SIGNED(1'b0), .EARLY_EXIT(1'b1)) u4 (.clk(clk), .rst(rst), .bus(if4));

  assign if0.start = start_v[0]; assign if0.mode_lt = mode_v[0]; assign if0.a = a_v[0][3:0]; assign if0.b = b_v[0][3:0];
  assign if1.start = start_v[1]; assign if1.mode_lt = mode_v[1]; assign if1.a = a_v[1][7:0]; assign if1.b = b_v[1][7:0];
  assign if2.start = start_v[2]; assign if2.mode_lt = mode_v[2]; assign if2.a = a_v[2][7:0]; assign if2.b = b_v[2][7:0];
  assign if3.start = start_v[3]; assign if3.mode_lt = mode_v[3]; assign if3.a = a_v[3][3:0]; assign if3.b = b_v[3][3:0];
  assign if4.start = start_v[4]; assign if4.mode_lt = mode_v[4]; assign if4.a = a_v[4];      assign if4.b = b_v[4];

  assign busy_v[0] = if0.busy; assign done_v[0] = if0.done; assign le_v[0] = if0.le; assign eq_v[0] = if0.eq;
  assign busy_v[1] = if1.busy; assign done_v[1] = if1.done; assign le_v[1] = if1.le; assign eq_v[1] = if1.eq;
  assign busy_v[2] = if2.busy; assign done_v[2] = if2.done; assign le_v[2] = if2.le; assign eq_v[2] = if2.eq;
  assign busy_v[3] = if3.busy; assign done_v[3] = if3.done; assign le_v[3] = if3.le; assign eq_v[3] = if3.eq;
  assign busy_v[4] = if4.busy; assign done_v[4] = if4.done; assign le_v[4] = if4.le; assign eq_v[4] = if4.eq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction; exp_lat counts edges from the start-sampling edge to the
  // edge after which done is high (first differing digit i -> i+1, full scan -> N).
  task automatic run(input string tag, input int idx, input logic [15:0] a, input logic [15:0] b,
                     input logic mlt, input logic exp_le, input logic exp_eq, input int exp_lat);
    int lat;
    @(negedge clk);
    a_v[idx] = a; b_v[idx] = b; mode_v[idx] = mlt; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    check({tag, "_busy"}, 32'(busy_v[idx]), 32'd1);
    lat = 0;
    while (!done_v[idx] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_le"}, 32'(le_v[idx]), 32'(exp_le));
    check({tag, "_eq"}, 32'(eq_v[idx]), 32'(exp_eq));
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, 32'(done_v[idx]), 32'd0);
    check({tag, "_busy_off"}, 32'(busy_v[idx]), 32'd0);
    $display("txn %s: a=%0h b=%0h mode_lt=%0b le=%0b eq=%0b lat=%0d", tag, a, b, mlt, le_v[idx], eq_v[idx], lat);
  endtask

  initial begin
    int pulses;
    int done_at;
    int busy_bad;
    for (int i = 0; i < 5; i++) begin
      start_v[i] = 1'b0; mode_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst%0d_le", i), 32'(le_v[i]), 32'd0);
      check($sformatf("rst%0d_eq", i), 32'(eq_v[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 4-bit unsigned, one bit per digit; latency = index of first differing bit from MSB + 1
    run("u_2_0", 0, 16'h2, 16'h0, 1'b0, 1'b0, 1'b0, 3);
    run("u_3_1", 0, 16'h3, 16'h1, 1'b0, 1'b0, 1'b0, 3);
    run("u_4_6", 0, 16'h4, 16'h6, 1'b0, 1'b1, 1'b0, 3);
    run("u_3_2", 0, 16'h3, 16'h2, 1'b0, 1'b0, 1'b0, 4);

    run("eq_le", 1, 16'h5A, 16'h5A, 1'b0, 1'b1, 1'b1, 4);
    run("eq_lt", 1, 16'h5A, 16'h5A, 1'b1, 1'b0, 1'b1, 4);

    run("sgn1_F_1", 3, 16'hF, 16'h1, 1'b0, 1'b1, 1'b0, 1);
    run("sgn0_F_1", 0, 16'hF, 16'h1, 1'b0, 1'b0, 1'b0, 1);
    run("sgn1_1_F", 3, 16'h1, 16'hF, 1'b1, 1'b0, 1'b0, 1);

    run("ee1_80_00", 1, 16'h80, 16'h00, 1'b0, 1'b0, 1'b0, 1);
    run("ee0_80_00", 2, 16'h80, 16'h00, 1'b0, 1'b0, 1'b0, 4);
    run("ee0_sticky", 2, 16'h13, 16'h31, 1'b1, 1'b1, 1'b0, 4);

    // start held through SCAN and DONE while operands change
    @(negedge clk);
    a_v[1] = 16'h01; b_v[1] = 16'h02; mode_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    pulses = 0; done_at = 0; busy_bad = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      a_v[1] = 16'hFF - 16'(c); b_v[1] = 16'h00; mode_v[1] = 1'b1;
      @(posedge clk); #1;
      if (done_v[1]) begin pulses++; done_at = c; end
      if (c <= 4 && !busy_v[1]) busy_bad++;
    end
    @(negedge clk);
    start_v[1] = 1'b0;
    check("hs_le", 32'(le_v[1]), 32'd1);
    check("hs_eq", 32'(eq_v[1]), 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[1]) pulses++;
    end
    check("hs_pulses", 32'(pulses), 32'd1);
    check("hs_done_at", 32'(done_at), 32'd4);
    check("hs_busy_gaps", 32'(busy_bad), 32'd0);
    check("hs_busy_idle", 32'(busy_v[1]), 32'd0);
    $display("txn hs: pulses=%0d done_at=%0d le=%0b", pulses, done_at, le_v[1]);

    // asynchronous abort mid-scan
    run("w16_pre", 4, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1, 16);
    @(negedge clk);
    a_v[4] = 16'hABCD; b_v[4] = 16'hABCD; mode_v[4] = 1'b0; start_v[4] = 1'b1;
    @(posedge clk); #1;
    start_v[4] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("abort_pre_busy", 32'(busy_v[4]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_v[4]), 32'd0);
    check("abort_done", 32'(done_v[4]), 32'd0);
    check("abort_le", 32'(le_v[4]), 32'd0);
    check("abort_eq", 32'(eq_v[4]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_v[4] || busy_v[4]) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    $display("txn abort: busy=%0b done=%0b le=%0b eq=%0b", busy_v[4], done_v[4], le_v[4], eq_v[4]);
    run("w16_post", 4, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
